traffic_phase_controller: RTL and testbench
===========================================

TRAFFIC_PHASE_CONTROLLER -- requirements
Module: traffic_phase_controller

Interface
REQ-001 Parameter GREEN_MIN, default 4: minimum green duration, in ticks.
REQ-002 Parameter GREEN_MAX, default 10: green duration at which competing demand forces a change, in ticks.
REQ-003 Parameter YELLOW_T, default 2: yellow duration, in ticks.
REQ-004 Parameter ALLRED_T, default 1: all-red clearance duration, in ticks.
REQ-005 Parameter WALK_T, default 3: walk duration, in ticks; legal only if 1 <= WALK_T <= GREEN_MIN < GREEN_MAX.
REQ-006 clk  input  1  system clock; all state changes on its rising edge.
REQ-007 rst_n  input  1  asynchronous, active-low reset.
REQ-008 tick  input  1  one-clk-wide time-base enable pulse; all durations are counted in ticks.
REQ-009 ped_ns_btn, ped_ew_btn  input  1 each  debounced pedestrian button levels.
REQ-010 car_ns, car_ew  input  1 each  debounced vehicle-presence levels.
REQ-011 ns_light, ew_light  output  3 each  one-hot lamp drive {R,Y,G}.
REQ-012 walk_ns, walk_ew  output  1 each  pedestrian walk lamps.
REQ-013 ped_ns_pend, ped_ew_pend  output  1 each  latched, unserved pedestrian request.
REQ-014 phase  output  3  current state encoding (see REQ-016).

Function
REQ-015 The block SHALL detect a 0->1 edge on each ped_*_btn with a one-flop history and, on the edge, set the matching ped_*_pend; a held button SHALL NOT re-set it, and an edge while already pending SHALL have no effect.
REQ-016 The FSM SHALL have six states: ALLRED_NS=0, NS_GREEN=1, NS_YELLOW=2, ALLRED_EW=3, EW_GREEN=4, EW_YELLOW=5; the cycle order is 0->1->2->3->4->5->0.
REQ-017 The tick timer SHALL clear to 0 on each state entry and increment only on clk edges with tick=1.
REQ-018 Timed states (yellow, all-red) SHALL exit on the tick on which timer==T-1, so each lasts exactly T ticks.
REQ-019 In X_GREEN, with "own" being X and "opposing" the other direction, demand = opposing car OR opposing ped_pend; elapsed = timer+1 evaluated on a tick.
REQ-020 X_GREEN SHALL exit to X_YELLOW on a tick where elapsed>=GREEN_MIN and opposing ped_pend=1.
REQ-021 X_GREEN SHALL exit to X_YELLOW on a tick where elapsed>=GREEN_MIN, opposing car=1 and own car=0 (gap-out).
REQ-022 X_GREEN SHALL exit to X_YELLOW on a tick where elapsed>=GREEN_MAX and demand=1 (max-out).
REQ-023 With no demand, X_GREEN SHALL hold indefinitely, with the timer saturating at GREEN_MAX-1.
REQ-024 On entry to X_GREEN the block SHALL capture ped_x_pend into a served flag and clear ped_x_pend in the same cycle; an edge arriving in that same cycle SHALL count as served, not left pending.
REQ-025 walk_x SHALL be 1 while in X_GREEN with the served flag set and timer<WALK_T, and 0 otherwise, including in yellow.
REQ-026 A ped_x edge during X_GREEN after entry SHALL stay pending until the next X_GREEN.
REQ-027 Lamp decode: X_GREEN gives X=G and other=R; X_YELLOW gives X=Y and other=R; ALLRED states give both R; exactly one lamp bit per direction SHALL be 1 at all times.
REQ-028 All outputs SHALL be registered or decoded only from registered state, with no combinational path from any input.

Reset
REQ-029 While rst_n=0 (asynchronous): state=ALLRED_NS, timer=0, pend and served flags=0, button history=0, ns_light=ew_light=100, walk=0, phase=0.
REQ-030 Reset asserted mid-phase SHALL abort immediately to the REQ-029 values; after release the FSM SHALL run ALLRED_NS for ALLRED_T ticks, then NS_GREEN.

Verification (default parameters, tick every 4 clk)
REQ-031 Reset, no inputs -> after 1 tick NS_GREEN (ns=001, ew=100); holds 20+ ticks; phase stays 1.
REQ-032 In NS_GREEN at timer 0, pulse ped_ew_btn -> ped_ew_pend=1; yellow on the 4th tick, 2 ticks yellow, 1 tick all-red, then EW_GREEN with walk_ew=1 for 3 ticks and ped_ew_pend=0.
REQ-033 car_ew=1 and car_ns=1 held -> NS_GREEN lasts exactly 10 ticks (max-out); car_ns drops at tick 6 -> exit on tick 6 (gap-out, since >=4).
REQ-034 ped_ns_btn edge in the same clk as NS_GREEN entry -> walk_ns=1 for 3 ticks and pend stays 0; second edge mid-green -> pend=1 through EW phases, served at next NS_GREEN.
REQ-035 rst_n pulled low mid EW_YELLOW -> same cycle ns=ew=100, phase=0, pend=0; recovery per REQ-030.
REQ-036 A held button (one edge) -> a single request; tick=0 held -> state and timer frozen; lamp one-hot checked every cycle.

Source files
------------

// File: rtl/traffic_phase_controller.sv
// traffic_phase_controller: two-way intersection phase FSM with ped latches, gap-out and max-out
module traffic_phase_controller #(
  parameter int GREEN_MIN = 4,
  parameter int GREEN_MAX = 10,
  parameter int YELLOW_T  = 2,
  parameter int ALLRED_T  = 1,
  parameter int WALK_T    = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       ped_ns_btn,
  input  logic       ped_ew_btn,
  input  logic       car_ns,
  input  logic       car_ew,
  output logic [2:0] ns_light,
  output logic [2:0] ew_light,
  output logic       walk_ns,
  output logic       walk_ew,
  output logic       ped_ns_pend,
  output logic       ped_ew_pend,
  output logic [2:0] phase
);
  localparam int TW = $clog2(GREEN_MAX + YELLOW_T + ALLRED_T + 1);
  localparam logic [TW-1:0] G_MIN  = TW'(GREEN_MIN);
  localparam logic [TW-1:0] G_MAX  = TW'(GREEN_MAX);
  localparam logic [TW-1:0] G_TOP  = TW'(GREEN_MAX - 1);
  localparam logic [TW-1:0] Y_TOP  = TW'(YELLOW_T - 1);
  localparam logic [TW-1:0] A_TOP  = TW'(ALLRED_T - 1);
  localparam logic [TW-1:0] WALK_V = TW'(WALK_T);

  typedef enum logic [2:0] {
    ALLRED_NS = 3'd0,
    NS_GREEN  = 3'd1,
    NS_YELLOW = 3'd2,
    ALLRED_EW = 3'd3,
    EW_GREEN  = 3'd4,
    EW_YELLOW = 3'd5
  } state_t;

  state_t        state, state_nx;
  logic [TW-1:0] timer, elapsed;
  logic          btn_ns_q, btn_ew_q, served_ns, served_ew;
  logic          rise_ns, rise_ew, enter_ns, enter_ew;
  logic          ns_g, ew_g, green, own_car, opp_car, opp_pend;
  logic          go_green, done_y, done_ar;

  assign rise_ns  = ped_ns_btn & ~btn_ns_q;
  assign rise_ew  = ped_ew_btn & ~btn_ew_q;
  assign ns_g     = state == NS_GREEN;
  assign ew_g     = state == EW_GREEN;
  assign green    = ns_g | ew_g;
  assign own_car  = ns_g ? car_ns : car_ew;
  assign opp_car  = ns_g ? car_ew : car_ns;
  assign opp_pend = ns_g ? ped_ew_pend : ped_ns_pend;
  assign elapsed  = timer + 1'b1;
  assign go_green = tick && ((elapsed >= G_MIN && (opp_pend || (opp_car && !own_car))) ||
                             (elapsed >= G_MAX && (opp_car || opp_pend)));
  assign done_y   = tick && timer == Y_TOP;
  assign done_ar  = tick && timer == A_TOP;
  assign enter_ns = state_nx == NS_GREEN && !ns_g;
  assign enter_ew = state_nx == EW_GREEN && !ew_g;

  // next phase: timed states leave on their last tick, greens leave on demand
  always_comb begin
    state_nx = state;
    case (state)
      ALLRED_NS: if (done_ar) state_nx = NS_GREEN;
      NS_GREEN:  if (go_green) state_nx = NS_YELLOW;
      NS_YELLOW: if (done_y) state_nx = ALLRED_EW;
      ALLRED_EW: if (done_ar) state_nx = EW_GREEN;
      EW_GREEN:  if (go_green) state_nx = EW_YELLOW;
      EW_YELLOW: if (done_y) state_nx = ALLRED_NS;
      default:   state_nx = ALLRED_NS;
    endcase
  end

  // phase register and tick timer; timer restarts on every phase change and parks in green
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ALLRED_NS;
      timer <= '0;
    end else begin
      state <= state_nx;
      timer <= (state_nx != state) ? '0 : (tick && !(green && timer == G_TOP)) ? elapsed : timer;
    end
  end

  // button edge latches; entering a green hands its pending request (and a same-cycle edge) to served
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_ns_q    <= 1'b0;
      btn_ew_q    <= 1'b0;
      ped_ns_pend <= 1'b0;
      ped_ew_pend <= 1'b0;
      served_ns   <= 1'b0;
      served_ew   <= 1'b0;
    end else begin
      btn_ns_q    <= ped_ns_btn;
      btn_ew_q    <= ped_ew_btn;
      ped_ns_pend <= enter_ns ? 1'b0 : ped_ns_pend | rise_ns;
      ped_ew_pend <= enter_ew ? 1'b0 : ped_ew_pend | rise_ew;
      served_ns   <= enter_ns ? ped_ns_pend | rise_ns : served_ns;
      served_ew   <= enter_ew ? ped_ew_pend | rise_ew : served_ew;
    end
  end

  assign ns_light = ns_g ? 3'b001 : (state == NS_YELLOW) ? 3'b010 : 3'b100;
  assign ew_light = ew_g ? 3'b001 : (state == EW_YELLOW) ? 3'b010 : 3'b100;
  assign walk_ns  = ns_g && served_ns && timer < WALK_V;
  assign walk_ew  = ew_g && served_ew && timer < WALK_V;
  assign phase    = state;
endmodule

// File: tb/tb_traffic_phase_controller.sv
// tb_traffic_phase_controller: table-driven green-exit vectors plus scripted phase sequences
module tb_traffic_phase_controller;
  logic clk = 0, rst_n = 0, tick = 0;
  logic ped_ns_btn = 0, ped_ew_btn = 0, car_ns = 0, car_ew = 0;
  logic [2:0] ns_light, ew_light, phase;
  logic walk_ns, walk_ew, ped_ns_pend, ped_ew_pend;
  int tests = 0, failed = 0;

  localparam int PH = 0, NS = 1, EW = 2, WN = 3, WE = 4, PN = 5, PE = 6;

  typedef struct {string name; int sel; logic [2:0] val;} exp_t;
  typedef struct {logic cns; logic cew; logic ped; int ex;} vec_t;
  exp_t sb[$];
  int exit_q[$];
  vec_t tbl[6];

  always #5 clk = ~clk;

  traffic_phase_controller dut (
    .clk(clk), .rst_n(rst_n), .tick(tick),
    .ped_ns_btn(ped_ns_btn), .ped_ew_btn(ped_ew_btn),
    .car_ns(car_ns), .car_ew(car_ew),
    .ns_light(ns_light), .ew_light(ew_light),
    .walk_ns(walk_ns), .walk_ew(walk_ew),
    .ped_ns_pend(ped_ns_pend), .ped_ew_pend(ped_ew_pend),
    .phase(phase)
  );

  function automatic logic [2:0] get(input int s);
    case (s)
      PH: return phase;
      NS: return ns_light;
      EW: return ew_light;
      WN: return {2'b0, walk_ns};
      WE: return {2'b0, walk_ew};
      PN: return {2'b0, ped_ns_pend};
      default: return {2'b0, ped_ew_pend};
    endcase
  endfunction

  task automatic ex(input string n, input int s, input logic [2:0] v);
    exp_t e;
    e.name = n; e.sel = s; e.val = v;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    logic [2:0] act;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      act = get(e.sel);
      tests++;
      if (act !== e.val) begin
        failed++;
        $display("FAIL %s: got %b, expected %b", e.name, act, e.val);
      end
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      tests++;
      if (!$onehot(ns_light) || !$onehot(ew_light)) begin
        failed++;
        $display("FAIL lamp_onehot: got ns=%b ew=%b, expected one-hot each", ns_light, ew_light);
      end
    end
  endtask

  task automatic tk(input int n);
    repeat (n) begin
      tick = 1;
      cyc(1);
      tick = 0;
      cyc(3);
    end
  endtask

  task automatic do_reset();
    rst_n = 0;
    {ped_ns_btn, ped_ew_btn, car_ns, car_ew, tick} = '0;
    cyc(2);
    rst_n = 1;
    cyc(1);
  endtask

  initial begin
    tbl[0] = '{1'b0, 1'b1, 1'b0, 4};
    tbl[1] = '{1'b1, 1'b1, 1'b0, 10};
    tbl[2] = '{1'b1, 1'b0, 1'b0, 0};
    tbl[3] = '{1'b0, 1'b0, 1'b0, 0};
    tbl[4] = '{1'b1, 1'b0, 1'b1, 4};
    tbl[5] = '{1'b1, 1'b1, 1'b1, 4};

    cyc(2);
    ex("rst_phase", PH, 3'd0); ex("rst_ns", NS, 3'b100); ex("rst_ew", EW, 3'b100);
    ex("rst_walk_ns", WN, 0); ex("rst_walk_ew", WE, 0);
    ex("rst_pend_ns", PN, 0); ex("rst_pend_ew", PE, 0);
    drain();
    rst_n = 1;
    cyc(1);
    ex("allred_before_tick", PH, 3'd0); drain();
    tk(1);
    ex("idle_ns_green", PH, 3'd1); ex("idle_ns_g", NS, 3'b001); ex("idle_ew_r", EW, 3'b100); drain();
    tk(20);
    ex("idle_hold_phase", PH, 3'd1); ex("idle_hold_ns", NS, 3'b001); drain();

    for (int i = 0; i < 6; i++) begin
      int got;
      do_reset();
      car_ns = tbl[i].cns;
      car_ew = tbl[i].cew;
      tk(1);
      exit_q.push_back(tbl[i].ex);
      got = 0;
      for (int t = 1; t <= 25 && got == 0; t++) begin
        if (t == 1 && tbl[i].ped) ped_ew_btn = 1;
        tk(1);
        ped_ew_btn = 0;
        if (phase != 3'd1) got = t;
      end
      begin
        int want;
        want = exit_q.pop_front();
        tests++;
        if (got != want) begin
          failed++;
          $display("FAIL tbl_exit_tick[%0d]: got %0d, expected %0d", i, got, want);
        end
      end
    end

    do_reset();
    tk(1);
    ped_ew_btn = 1;
    tk(1);
    ex("ped_ew_latched", PE, 1); ex("ped_ew_still_green", PH, 3'd1); drain();
    tk(2);
    ex("ped_ew_green_t3", PH, 3'd1); drain();
    tk(1);
    ex("ped_ew_yellow_t4", PH, 3'd2); ex("ped_ew_ns_y", NS, 3'b010); ex("ped_ew_ew_r", EW, 3'b100);
    ex("ped_ew_walk_in_y", WE, 0); drain();
    tk(1);
    ex("ped_ew_yellow2", PH, 3'd2); drain();
    tk(1);
    ex("ped_ew_allred", PH, 3'd3); ex("ped_ew_allred_ns", NS, 3'b100); ex("ped_ew_allred_ew", EW, 3'b100); drain();
    tk(1);
    ex("ped_ew_ew_green", PH, 3'd4); ex("ped_ew_ew_g", EW, 3'b001); ex("ped_ew_ns_r", NS, 3'b100);
    ex("ped_ew_walk_on", WE, 1); ex("ped_ew_pend_clr", PE, 0); drain();
    tk(2);
    ex("ped_ew_walk_t2", WE, 1); drain();
    tk(1);
    ex("ped_ew_walk_off", WE, 0); ex("ped_ew_held_no_repend", PE, 0); ex("ped_ew_hold", PH, 3'd4); drain();
    ped_ew_btn = 0;

    do_reset();
    ped_ns_btn = 1;
    tk(1);
    ex("ns_entry_green", PH, 3'd1); ex("ns_entry_walk", WN, 1); ex("ns_entry_no_pend", PN, 0); drain();
    ped_ns_btn = 0;
    tk(2);
    ex("ns_walk_t2", WN, 1); drain();
    tk(1);
    ex("ns_walk_off", WN, 0); drain();
    ped_ns_btn = 1;
    tk(1);
    ped_ns_btn = 0;
    ex("ns_mid_pend", PN, 1); ex("ns_mid_green", PH, 3'd1); drain();
    ped_ew_btn = 1;
    tk(1);
    ped_ew_btn = 0;
    ex("ns_mid_ew_req", PH, 3'd1); drain();
    tk(1);
    ex("ns_to_yellow", PH, 3'd2); ex("ns_pend_y", PN, 1); drain();
    tk(3);
    ex("ew_green_reached", PH, 3'd4); ex("ns_pend_in_ew", PN, 1); ex("ew_walk", WE, 1); ex("ns_no_walk", WN, 0); drain();
    tk(4);
    ex("ew_yellow_by_ns_ped", PH, 3'd5); ex("ns_pend_ew_y", PN, 1); drain();
    tk(3);
    ex("ns_green_again", PH, 3'd1); ex("ns_pend_served", PN, 0); ex("ns_walk_served", WN, 1); drain();

    do_reset();
    tk(1);
    tick = 0;
    tk(2);
    car_ew = 1;
    cyc(20);
    ex("freeze_phase", PH, 3'd1); drain();
    tk(1);
    ex("freeze_timer_held", PH, 3'd1); drain();
    tk(1);
    ex("freeze_resume_exit", PH, 3'd2); drain();

    do_reset();
    tk(1);
    ped_ew_btn = 1;
    tk(1);
    ped_ew_btn = 0;
    tk(3);
    tk(3);
    ped_ns_btn = 1;
    tk(1);
    ped_ns_btn = 0;
    tk(3);
    ex("mid_ew_yellow", PH, 3'd5); ex("mid_ew_y", EW, 3'b010); ex("mid_ns_r", NS, 3'b100); ex("mid_pend", PN, 1); drain();
    #2 rst_n = 0;
    #1;
    ex("async_phase", PH, 3'd0); ex("async_ns", NS, 3'b100); ex("async_ew", EW, 3'b100);
    ex("async_pend", PN, 0); ex("async_walk", WE, 0); drain();
    #3 rst_n = 1;
    cyc(1);
    ex("recover_allred", PH, 3'd0); drain();
    tk(1);
    ex("recover_ns_green", PH, 3'd1); ex("recover_ns_g", NS, 3'b001); drain();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
